pll_clkgen: RTL

Parametrised, reconfigurable clock-derivation block clocked from `refclk`. It generates `NUM_CLOCKS` phase-aligned divided clocks, each with programmable divide ratio, high time (duty) and phase offset. It also produces matching single-cycle clock enables for downstream logic and a `locked` indication. It sits beside the board PLL in the clocking subsystem, producing slower derived clocks and enables without a second analog PLL, and accepts runtime reconfiguration over a valid/ready port.

---
 rtl/pll_clkgen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pll_clkgen.sv
// Purpose : derives NUM_CLOCKS phase-aligned divided clocks plus matching one-cycle enables from refclk.
// Latency : outputs registered; new config shows on outputs two edges after acceptance, locked LOCK_CYCLES later.
// Backpress: cfg_ready low only during the single S_HOLD cycle; requester holds cfg_valid until accepted.
//
// Ports:
//   refclk, rst_n                      clock and synchronous active-low reset
//   cfg_valid/cfg_ready                reconfiguration handshake
//   cfg_chan/cfg_div/cfg_high/cfg_phase  target channel, period, high time, start count
//   cfg_err                            one-cycle pulse for an accepted but invalid request
//   outclk/outclk_en                   divided clocks and their rising-cycle enables
//   locked                             outputs stable and phase-aligned
module pll_clkgen #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 64,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int LCW = $clog2(LOCK_CYCLES) + 1;
  localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_HIGH  = DIV_W'(DEFAULT_DIV / 2);
  localparam logic [CH_W:0]    NUM_CH    = (CH_W + 1)'(NUM_CLOCKS);
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_LOCKING = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [LCW-1:0]                   lock_cnt_q, lock_cnt_d;
  logic                             locked_q, locked_d;
  logic                             cfg_err_q, cfg_err_d;
  logic [NUM_CLOCKS-1:0]            outclk_q, outclk_d;
  logic [NUM_CLOCKS-1:0]            outclk_en_q, outclk_en_d;
  logic [NUM_CLOCKS-1:0][DIV_W-1:0] div_q, div_d;
  logic [NUM_CLOCKS-1:0][DIV_W-1:0] high_q, high_d;
  logic [NUM_CLOCKS-1:0][DIV_W-1:0] phase_q, phase_d;
  logic [NUM_CLOCKS-1:0][DIV_W-1:0] cnt_q, cnt_d;

  logic running;
  logic accept;
  logic cfg_ok;

  assign running   = (state_q != S_HOLD);
  assign cfg_ready = running;
  assign accept    = cfg_valid && running;

  // Keeping high < div and phase < div guarantees every counter stays in [0, div-1].
  assign cfg_ok = ({1'b0, cfg_chan} < NUM_CH) &&
                  (cfg_div >= DIV_W'(2)) &&
                  (cfg_high != '0) &&
                  (cfg_high < cfg_div) &&
                  (cfg_phase < cfg_div);

  // Lock FSM: next state, lock counter, registered status outputs.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_HOLD: begin
        state_d    = S_LOCKING;
        lock_cnt_d = '0;
      end
      S_LOCKING: begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
    // A good reconfiguration restarts alignment and lock from scratch.
    if (accept && cfg_ok) begin
      state_d = S_HOLD;
    end
    locked_d  = (state_d == S_LOCKED);
    cfg_err_d = accept && !cfg_ok;
  end

  // Per-channel configuration, counters and output registers.
  always_comb begin
    div_d       = div_q;
    high_d      = high_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    outclk_d    = '0;
    outclk_en_d = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (accept && cfg_ok && (cfg_chan == CH_W'(i))) begin
        div_d[i]   = cfg_div;
        high_d[i]  = cfg_high;
        phase_d[i] = cfg_phase;
      end
      // In S_HOLD every channel reloads its phase on the same edge, which is
      // what keeps the channels aligned to each other after any reconfig.
      if (!running) begin
        cnt_d[i] = phase_q[i];
      end else if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
      outclk_d[i]    = running && (cnt_q[i] < high_q[i]);
      outclk_en_d[i] = running && (cnt_q[i] == '0);
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      outclk_q    <= '0;
      outclk_en_q <= '0;
      div_q       <= {NUM_CLOCKS{DEF_DIV}};
      high_q      <= {NUM_CLOCKS{DEF_HIGH}};
      phase_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      cfg_err_q   <= cfg_err_d;
      outclk_q    <= outclk_d;
      outclk_en_q <= outclk_en_d;
      div_q       <= div_d;
      high_q      <= high_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
    end
  end

  assign outclk    = outclk_q;
  assign outclk_en = outclk_en_q;
  assign locked    = locked_q;
  assign cfg_err   = cfg_err_q;

endmodule
